// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, ShiftRows index table, xtime.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SUB,
        ST_SRMC,
        ST_ARK,
        ST_UNLOAD
    } state_t;

    // ShiftRows source index: new byte i (row i%4, column i/4) comes from
    // old byte (i%4) + 4*(((i/4) + (i%4)) % 4).
    localparam logic [15:0][3:0] SR_TABLE = {
        4'd11, 4'd6, 4'd1, 4'd12,
        4'd7,  4'd2, 4'd13, 4'd8,
        4'd3,  4'd14, 4'd9, 4'd4,
        4'd15, 4'd10, 4'd5, 4'd0
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (linear over XOR).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns.sv
// MixColumns on one 4-byte column; byte r (row r) at bits [8r+7:8r].
// Purely linear, so it is applied to each Boolean share independently.
module mix_columns
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[7:0];
    assign a1 = col_in[15:8];
    assign a2 = col_in[23:16];
    assign a3 = col_in[31:24];

    assign col_out[7:0]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_out[15:8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_out[31:24] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/masked_state_engine.sv
// Masked AES round sequencer: holds NSHARES Boolean shares of the 16-byte
// state, streams bytes through an external masked S-box, applies the linear
// layers share-wise and never recombines shares.
module masked_state_engine
    import aes_pkg::*;
#(
    parameter int NSHARES  = 2,
    parameter int SBOX_LAT = 4,
    parameter int NROUNDS  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NSHARES-1:0]   in_data,
    input  logic [8*NSHARES-1:0]   rk_data,
    output logic [3:0]             rk_round,
    output logic [3:0]             rk_idx,
    output logic [8*NSHARES-1:0]   sbox_in,
    output logic                   sbox_valid,
    input  logic [8*NSHARES-1:0]   sbox_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NSHARES-1:0]   out_data,
    output logic                   busy,
    output logic [3:0]             round_num
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);
    localparam logic [4:0] SUB_LAST   = 5'(15 + SBOX_LAT);
    localparam logic [4:0] BYTE_LAST  = 5'd15;

    state_t state, next_state;

    logic [4:0]                    cnt;
    logic [NSHARES-1:0][15:0][7:0] st;
    logic [NSHARES-1:0][15:0][7:0] shifted;
    logic [NSHARES-1:0][15:0][7:0] mixed;
    logic [SBOX_LAT-1:0]           dl_vld;
    logic [SBOX_LAT-1:0][3:0]      dl_idx;
    logic                          load_acc;
    logic                          issue;
    logic                          out_acc;
    logic                          last_round;

    assign last_round = (round_num == LAST_ROUND);

    // State register; reset abandons any block in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and all handshake/request outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        sbox_valid = 1'b0;
        sbox_in    = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        rk_round   = '0;
        rk_idx     = '0;
        busy       = (state != ST_IDLE);
        load_acc   = 1'b0;
        issue      = 1'b0;
        out_acc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                rk_idx   = cnt[3:0];
                load_acc = in_valid;
                if (in_valid && (cnt == BYTE_LAST)) begin
                    next_state = ST_SUB;
                end
            end
            ST_SUB: begin
                if (cnt < 5'd16) begin
                    issue      = 1'b1;
                    sbox_valid = 1'b1;
                    for (int unsigned s = 0; s < NSHARES; s++) begin
                        sbox_in[8*s +: 8] = st[s][cnt[3:0]];
                    end
                end
                if (cnt == SUB_LAST) begin
                    next_state = ST_SRMC;
                end
            end
            ST_SRMC: begin
                next_state = ST_ARK;
            end
            ST_ARK: begin
                rk_round = round_num;
                rk_idx   = cnt[3:0];
                if (cnt == BYTE_LAST) begin
                    next_state = last_round ? ST_UNLOAD : ST_SUB;
                end
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_acc   = out_ready;
                for (int unsigned s = 0; s < NSHARES; s++) begin
                    out_data[8*s +: 8] = st[s][cnt[3:0]];
                end
                if (out_ready && (cnt == BYTE_LAST)) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ShiftRows applied to every share through the shared index table
    always_comb begin
        shifted = '0;
        for (int unsigned s = 0; s < NSHARES; s++) begin
            for (int unsigned i = 0; i < 16; i++) begin
                shifted[s][i] = st[s][SR_TABLE[i]];
            end
        end
    end

    for (genvar s = 0; s < NSHARES; s++) begin : g_share
        for (genvar c = 0; c < 4; c++) begin : g_col
            mix_columns u_mix_columns (
                .col_in  (shifted[s][4*c+3:4*c]),
                .col_out (mixed[s][4*c+3:4*c])
            );
        end
    end

    // Datapath: byte counter, round counter, state shares, S-box index delay line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= '0;
            cnt       <= '0;
            round_num <= '0;
            dl_vld    <= '0;
            dl_idx    <= '0;
        end else begin
            // The delay line tracks which byte each S-box result belongs to,
            // so write-back never depends on the S-box's own handshake.
            dl_vld[0] <= issue;
            dl_idx[0] <= cnt[3:0];
            for (int unsigned k = 1; k < SBOX_LAT; k++) begin
                dl_vld[k] <= dl_vld[k-1];
                dl_idx[k] <= dl_idx[k-1];
            end

            case (state)
                ST_IDLE: begin
                    cnt       <= '0;
                    round_num <= '0;
                end
                ST_LOAD: begin
                    if (load_acc) begin
                        for (int unsigned s = 0; s < NSHARES; s++) begin
                            st[s][cnt[3:0]] <= in_data[8*s +: 8] ^ rk_data[8*s +: 8];
                        end
                        if (cnt == BYTE_LAST) begin
                            cnt       <= '0;
                            round_num <= 4'd1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ST_SUB: begin
                    if (dl_vld[SBOX_LAT-1]) begin
                        for (int unsigned s = 0; s < NSHARES; s++) begin
                            st[s][dl_idx[SBOX_LAT-1]] <= sbox_out[8*s +: 8];
                        end
                    end
                    if (cnt == SUB_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_SRMC: begin
                    st <= last_round ? shifted : mixed;
                end
                ST_ARK: begin
                    for (int unsigned s = 0; s < NSHARES; s++) begin
                        st[s][cnt[3:0]] <= st[s][cnt[3:0]] ^ rk_data[8*s +: 8];
                    end
                    if (cnt == BYTE_LAST) begin
                        cnt <= '0;
                        if (!last_round) begin
                            round_num <= round_num + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_acc) begin
                        if (cnt == BYTE_LAST) begin
                            cnt       <= '0;
                            round_num <= '0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_state_engine.sv
// Bench for masked_state_engine: reference masked S-box and round-key source,
// table of encryption vectors, scoreboard of expected ciphertext bytes.
module tb_masked_state_engine;

    localparam int NSHARES  = 2;
    localparam int SBOX_LAT = 4;
    localparam int NROUNDS  = 10;
    localparam int W        = 8 * NSHARES;
    localparam int EXP_LAT  = 16 + NROUNDS * (33 + SBOX_LAT);
    localparam int NVEC     = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [W-1:0]  rk_data;
    logic [3:0]    rk_round;
    logic [3:0]    rk_idx;
    logic [W-1:0]  sbox_in;
    logic          sbox_valid;
    logic [W-1:0]  sbox_out;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
    logic [3:0]    round_num;

    masked_state_engine #(
        .NSHARES  (NSHARES),
        .SBOX_LAT (SBOX_LAT),
        .NROUNDS  (NROUNDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rk_data    (rk_data),
        .rk_round   (rk_round),
        .rk_idx     (rk_idx),
        .sbox_in    (sbox_in),
        .sbox_valid (sbox_valid),
        .sbox_out   (sbox_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .round_num  (round_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] SB [256];
    logic [15:0][15:0][7:0]             rkb;
    logic [15:0][15:0][NSHARES-2:0][7:0] rkm;
    logic [7:0] sb_q [$];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        bit           in_stall;
        bit           out_stall;
        bit           start_pulse;
        bit           abort;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, r, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            SB[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [W-1:0] split(input logic [7:0] b);
        logic [W-1:0] r = '0;
        logic [7:0]   acc = b;
        logic [7:0]   m;
        for (int s = 0; s < NSHARES - 1; s++) begin
            m = 8'($urandom());
            r[8*s +: 8] = m;
            acc = acc ^ m;
        end
        r[8*(NSHARES-1) +: 8] = acc;
        return r;
    endfunction

    function automatic logic [7:0] unmask(input logic [W-1:0] x);
        logic [7:0] acc = '0;
        for (int s = 0; s < NSHARES; s++) acc = acc ^ x[8*s +: 8];
        return acc;
    endfunction

    // AES-128 style key schedule producing NROUNDS+1 round keys, plus fresh masks
    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4 * (NROUNDS + 1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        rkb = '0;
        for (int r = 0; r <= NROUNDS; r++)
            for (int k = 0; k < 16; k++)
                rkb[r][k] = w[4*r + k/4][31 - 8*(k%4) -: 8];
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++)
                for (int s = 0; s < NSHARES - 1; s++)
                    rkm[r][k][s] = 8'($urandom());
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkb[0][i];
        for (int r = 1; r <= NROUNDS; r++) begin
            for (int i = 0; i < 16; i++) s[i] = SB[s[i]];
            for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != NROUNDS) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkb[r][i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Round-key source: masked key byte for the requested (round, index)
    logic [7:0] rk_acc;
    always_comb begin
        rk_acc  = rkb[rk_round][rk_idx];
        rk_data = '0;
        for (int s = 0; s < NSHARES - 1; s++) begin
            rk_data[8*s +: 8] = rkm[rk_round][rk_idx][s];
            rk_acc = rk_acc ^ rkm[rk_round][rk_idx][s];
        end
        rk_data[8*(NSHARES-1) +: 8] = rk_acc;
    end

    // Reference masked S-box: fixed latency, re-randomised output shares,
    // random garbage whenever no result is due
    logic [SBOX_LAT-1:0] sbp_v = '0;
    logic [7:0]          sbp_d [SBOX_LAT];
    always @(posedge clk) begin
        for (int k = SBOX_LAT - 1; k > 0; k--) begin
            sbp_v[k] = sbp_v[k-1];
            sbp_d[k] = sbp_d[k-1];
        end
        sbp_v[0] = sbox_valid;
        sbp_d[0] = SB[unmask(sbox_in)];
        if (sbp_v[SBOX_LAT-1]) sbox_out <= split(sbp_d[SBOX_LAT-1]);
        else                   sbox_out <= W'({$urandom(), $urandom()});
    end

    task automatic check_all_zero(input string name);
        check(name, {busy, in_ready, out_valid, sbox_valid, round_num, rk_round, rk_idx,
                     sbox_in, out_data}, '0);
    endtask

    task automatic run_block(input vec_t v);
        int sent, guard, got, t_in, t_out;
        bit pulsed, seen, aborted, stalled;
        logic [W-1:0] held;

        expand_key(v.key);
        if (!v.abort)
            for (int i = 0; i < 16; i++) sb_q.push_back(v.ct[127-8*i -: 8]);

        @(posedge clk); #1 start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1 start = 1'b0;

        sent = 0; guard = 0; t_in = 0;
        while (sent < 16 && guard < 500) begin
            @(posedge clk); #1;
            in_valid = v.in_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = split(v.pt[127-8*sent -: 8]);
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (sent == 0) t_in = cyc;
                sent++;
            end
            guard++;
        end
        // Keep presenting junk so that in_valid outside LOAD is exercised
        @(posedge clk); #1 in_valid = 1'b1; in_data = W'({$urandom(), $urandom()});
        check("load_count", sent, 16);

        seen = 0; pulsed = 0; aborted = 0; guard = 0; t_out = 0;
        while (!seen && !aborted && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (v.abort && rk_round == 4'd3) begin
                rst = 1'b0;
                #1;
                check_all_zero("abort_outputs_zero");
                repeat (2) @(posedge clk);
                #1 rst = 1'b1; in_valid = 1'b0;
                aborted = 1;
            end else if (v.start_pulse && !pulsed && round_num == 4'd5 && sbox_valid) begin
                start = 1'b1;
                pulsed = 1;
                @(posedge clk); #1 start = 1'b0;
            end else if (out_valid) begin
                seen = 1;
                t_out = cyc;
            end
        end

        if (v.abort) begin
            check("abort_reached_ark3", aborted, 1);
        end else begin
            in_valid = 1'b0;
            check("out_valid_seen", seen, 1);
            if (v.start_pulse) check("start_pulse_in_sub5", pulsed, 1);
            if (!v.in_stall) check("latency", t_out - t_in, EXP_LAT);
            stalled = 1;
            held = out_data;
            got = 0; guard = 0;
            while (seen && got < 16 && guard < 500) begin
                @(posedge clk); #1 out_ready = v.out_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                guard++;
                if (stalled) check("hold_while_stalled", {out_valid, out_data}, {1'b1, held});
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) check("scoreboard_underflow", 0, 1);
                    else check("ct_byte", unmask(out_data), sb_q.pop_front());
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = out_data;
                end
            end
            check("unload_count", got, 16);
            @(posedge clk); #1 out_ready = 1'b0;
            check("idle_after_unload", {busy, out_valid, round_num}, '0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rkb = '0; rkm = '0;
        build_sbox();

        vecs[0] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, in_stall: 0, out_stall: 0, start_pulse: 0, abort: 0};
        vecs[1] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32, in_stall: 0, out_stall: 0, start_pulse: 0, abort: 0};
        vecs[2] = vecs[0]; vecs[2].in_stall = 1; vecs[2].out_stall = 1;
        vecs[3] = vecs[0]; vecs[3].start_pulse = 1;
        vecs[4] = vecs[1]; vecs[4].abort = 1;
        vecs[5] = vecs[0];
        for (int v = 6; v < NVEC; v++) begin
            vecs[v].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[v].key = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_key(vecs[v].key);
            vecs[v].ct = aes_model(vecs[v].pt);
            vecs[v].in_stall = (v == 7);
            vecs[v].out_stall = (v == 6);
            vecs[v].start_pulse = 0;
            vecs[v].abort = 0;
        end

        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_outputs_zero");
        @(negedge clk) rst = 1'b1;

        for (int v = 0; v < NVEC; v++) run_block(vecs[v]);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/masked_state_engine.md
MASKED_STATE_ENGINE -- requirements
Module: masked_state_engine

Interface
REQ-001 SHALL have parameter NSHARES, default 2, number of Boolean shares per byte (legal 2..4).
REQ-002 SHALL have parameter SBOX_LAT, default 4, fixed latency in cycles of the external masked S-box (legal 1..8).
REQ-003 SHALL have parameter NROUNDS, default 10, number of AES rounds.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin an encryption; sampled only in IDLE.
REQ-007 in_valid  in  1, in_ready  out  1, in_data  in  8*NSHARES  plaintext byte shares, share s at bits [8s+7:8s].
REQ-008 rk_data  in  8*NSHARES  round-key byte shares for (rk_round, rk_idx), valid combinationally in the same cycle.
REQ-009 rk_round  out  4, rk_idx  out  4  round-key byte request.
REQ-010 sbox_in  out  8*NSHARES, sbox_valid  out  1, sbox_out  in  8*NSHARES  external masked S-box, result SBOX_LAT cycles after issue.
REQ-011 out_valid  out  1, out_ready  in  1, out_data  out  8*NSHARES  ciphertext byte shares, never unmasked.
REQ-012 busy  out  1, round_num  out  4  (current round, 0 during LOAD).

Function
REQ-013 Byte index i SHALL map to column i/4, row i%4; bytes enter and leave in order 0..15.
REQ-014 SHALL implement FSM IDLE -> LOAD -> {SUB -> SRMC -> ARK} x NROUNDS -> UNLOAD -> IDLE.
REQ-015 IDLE: in_ready=0, busy=0; start=1 -> LOAD next cycle; start in any other state SHALL be ignored.
REQ-016 LOAD: in_ready=1; on in_valid&in_ready store byte rk_idx as in_data XOR rk_data, with rk_round=0 and rk_idx equal to the load count; after 16 accepted bytes go to SUB with round_num=1.
REQ-017 SUB: issue bytes 0..15 on 16 consecutive cycles with sbox_valid=1; write returned byte j back at issue(j)+SBOX_LAT using an internal SBOX_LAT-deep index delay line; leave after 16+SBOX_LAT cycles.
REQ-018 SRMC: one cycle; apply ShiftRows to each share, then MixColumns to each share unless round_num==NROUNDS.
REQ-019 ARK: 16 cycles; byte k XOR= rk_data with rk_round=round_num and rk_idx=k; then, if round_num==NROUNDS, go to UNLOAD, else increment round_num and go to SUB.
REQ-020 UNLOAD: out_valid=1 with out_data=byte k; advance only on out_ready; with out_ready low, hold out_data and k stable; after byte 15 is accepted go to IDLE.
REQ-021 Linear steps SHALL act per share; shares SHALL never be XOR-combined inside the block.
REQ-022 Latency with no stalls: 16 + NROUNDS*(33+SBOX_LAT) cycles from first accepted input to first out_valid (386 at defaults).
REQ-023 in_valid outside LOAD and sbox_out outside SUB write-back slots SHALL be ignored.

Reset
REQ-024 rst low SHALL immediately force IDLE, clear state array and delay line to zero, and zero all of busy, in_ready, out_valid, sbox_valid, round_num, rk_round, rk_idx, sbox_in and out_data.
REQ-025 Reset mid-operation SHALL abandon the block; the first start after release begins a fresh LOAD.

Structure
REQ-026 The shared package aes_pkg SHALL hold the FSM state encoding, the ShiftRows index table and the xtime function.
REQ-027 SHALL instantiate the existing mix_columns sub-module once per share per column (4*NSHARES instances).
REQ-028 The S-box and its PRNG SHALL remain outside this block.

Verification
REQ-029 NSHARES=2, SBOX_LAT=4, reference masked S-box model: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, random share splits -> XOR of out shares = 69c4e0d86a7b0430d8cdb78070b4c55a, first out_valid 386 cycles after first accepted input.
REQ-030 NSHARES=3, SBOX_LAT=1, same vectors -> same ciphertext, latency 16+10*34=356.
REQ-031 in_valid toggled 50% during LOAD and out_ready toggled 50% during UNLOAD -> same ciphertext, out_data held stable while stalled.
REQ-032 start pulsed during SUB of round 5 -> no effect; result is the correct ciphertext.
REQ-033 rst asserted during ARK of round 3 -> all outputs zero immediately; a new start then gives the correct ciphertext.
REQ-034 sbox_out driven with garbage outside write-back slots -> ciphertext unaffected.
